// File: rtl/spi_command_framer_pkg.sv
// Shared types and constants for the SPI command framer and its neighbours.
package spi_command_framer_pkg;

    // Framer states; the encoding is left to the synthesis tool.
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN_HI,
        LEN_LO,
        PAYLOAD,
        DRAIN
    } framer_state_t;

    // Command codes understood by the downstream store write controller.
    // The framer never decodes these; it forwards the command byte untouched.
    localparam logic [7:0] COMMAND_NOP           = 8'h00;
    localparam logic [7:0] COMMAND_WRITE_SPRITE  = 8'h01;
    localparam logic [7:0] COMMAND_WRITE_PALETTE = 8'h02;
    localparam logic [7:0] COMMAND_CLEAR         = 8'h03;

    // States in which a frame header or payload is still outstanding.
    function automatic logic state_is_busy(input framer_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == PAYLOAD);
    endfunction

endpackage

// File: rtl/spi_command_framer.sv
// Frames the synchronised SPI byte stream into command / length / payload
// fields. One frame per chip-select assertion: command byte, 16-bit
// big-endian payload length, then payload bytes. Truncated, oversize and
// overrun frames raise a one-cycle frame_error.
module spi_command_framer
    import spi_command_framer_pkg::*;
#(
    parameter logic [15:0] MAX_PAYLOAD = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cs_active,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  command,
    output logic [7:0]  data,
    output logic [15:0] data_index,
    output logic        data_read,
    output logic        frame_done,
    output logic        frame_error,
    output logic        busy
);

    framer_state_t state, state_n;
    logic [15:0]   len_q, len_n;
    logic [15:0]   count_q, count_n;
    logic [7:0]    command_n, data_n;
    logic [15:0]   data_index_n;
    logic          data_read_n, frame_done_n, frame_error_n, busy_n;
    // Set once a frame has already reported an error (or when the framer
    // comes out of reset mid-transaction) so DRAIN stays silent.
    logic          drain_err_q, drain_err_n;
    logic [15:0]   header_len;

    // Full payload length as it becomes known on the low length byte.
    assign header_len = {len_q[15:8], rx_byte};

    // Next-state, field capture and strobe generation.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n       = state;
        len_n         = len_q;
        count_n       = count_q;
        command_n     = command;
        data_n        = data;
        data_index_n  = data_index;
        data_read_n   = 1'b0;
        frame_done_n  = 1'b0;
        frame_error_n = 1'b0;
        drain_err_n   = drain_err_q;

        case (state)
            IDLE: begin
                if (cs_active) begin
                    state_n = CMD;
                end
            end

            CMD: begin
                if (rx_valid) begin
                    command_n = rx_byte;
                    if (cs_active) begin
                        state_n = LEN_HI;
                    end else begin
                        // Command arrived with the chip-select fall: header incomplete.
                        frame_error_n = 1'b1;
                        state_n       = IDLE;
                    end
                end else if (!cs_active) begin
                    state_n = IDLE;
                end
            end

            LEN_HI: begin
                if (rx_valid) begin
                    len_n[15:8] = rx_byte;
                end
                if (!cs_active) begin
                    frame_error_n = 1'b1;
                    state_n       = IDLE;
                end else if (rx_valid) begin
                    state_n = LEN_LO;
                end
            end

            LEN_LO: begin
                if (rx_valid) begin
                    len_n   = header_len;
                    count_n = 16'd0;
                    if (header_len == 16'd0) begin
                        frame_done_n = 1'b1;
                        state_n      = cs_active ? DRAIN : IDLE;
                    end else if (header_len > MAX_PAYLOAD) begin
                        frame_error_n = 1'b1;
                        drain_err_n   = 1'b1;
                        state_n       = cs_active ? DRAIN : IDLE;
                    end else if (cs_active) begin
                        state_n = PAYLOAD;
                    end else begin
                        frame_error_n = 1'b1;
                        state_n       = IDLE;
                    end
                end else if (!cs_active) begin
                    frame_error_n = 1'b1;
                    state_n       = IDLE;
                end
            end

            PAYLOAD: begin
                if (rx_valid) begin
                    data_n       = rx_byte;
                    data_index_n = count_q;
                    data_read_n  = 1'b1;
                    count_n      = count_q + 16'd1;
                    if (count_q == len_q - 16'd1) begin
                        // Final byte: the frame completes even if chip-select falls now.
                        frame_done_n = 1'b1;
                        state_n      = cs_active ? DRAIN : IDLE;
                    end else if (!cs_active) begin
                        frame_error_n = 1'b1;
                        state_n       = IDLE;
                    end
                end else if (!cs_active) begin
                    frame_error_n = 1'b1;
                    state_n       = IDLE;
                end
            end

            DRAIN: begin
                if (rx_valid && !drain_err_q) begin
                    // First overrun byte of the frame is reported; later ones are dropped.
                    frame_error_n = 1'b1;
                    drain_err_n   = 1'b1;
                end
                if (!cs_active) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = DRAIN;
            end
        endcase

        // Each new frame starts with a clean overrun flag.
        if (state_n == IDLE) begin
            drain_err_n = 1'b0;
        end

        busy_n = state_is_busy(state_n);
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Resetting into DRAIN with the overrun flag already set means a
            // reset mid-transaction stays silent until chip-select goes low.
            state       <= DRAIN;
            drain_err_q <= 1'b1;
            len_q       <= 16'd0;
            count_q     <= 16'd0;
            command     <= 8'd0;
            data        <= 8'd0;
            data_index  <= 16'd0;
            data_read   <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // same pre-edge values computed by the combinational block.
            state       <= state_n;
            drain_err_q <= drain_err_n;
            len_q       <= len_n;
            count_q     <= count_n;
            command     <= command_n;
            data        <= data_n;
            data_index  <= data_index_n;
            data_read   <= data_read_n;
            frame_done  <= frame_done_n;
            frame_error <= frame_error_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_spi_command_framer.sv
// Scoreboard bench for spi_command_framer: a frame-level reference model
// pushes expected strobes into a queue, a monitor pops and compares them.
module tb_spi_command_framer;

    localparam logic [15:0] MAX_PAYLOAD = 16'd16;

    typedef logic [7:0] byte_q_t[$];
    typedef enum int {EV_READ, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  cmd;
        logic [7:0]  data;
        logic [15:0] idx;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cs_active;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  command;
    logic [7:0]  data;
    logic [15:0] data_index;
    logic        data_read;
    logic        frame_done;
    logic        frame_error;
    logic        busy;

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t exp_q[$];

    spi_command_framer #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (
        .clock       (clock),
        .reset       (reset),
        .cs_active   (cs_active),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .command     (command),
        .data        (data),
        .data_index  (data_index),
        .data_read   (data_read),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [7:0] c, input logic [7:0] d, input logic [15:0] i);
        ev_t e;
        e.kind = k; e.cmd = c; e.data = d; e.idx = i;
        exp_q.push_back(e);
    endtask

    // Expected strobes for one frame, derived from the frame rules alone:
    // b is every byte seen while chip-select was high, cs_falls says whether
    // chip-select then dropped (as opposed to a reset cutting the frame).
    task automatic model_frame(input byte_q_t b, input bit cs_falls);
        int n, pay, len;
        n = b.size();
        if (n == 0) return;
        if (n < 3) begin
            if (cs_falls) push_ev(EV_ERR, 0, 0, 0);
            return;
        end
        len = int'(b[1]) * 256 + int'(b[2]);
        pay = n - 3;
        if (len == 0) begin
            push_ev(EV_DONE, 0, 0, 0);
            if (pay > 0) push_ev(EV_ERR, 0, 0, 0);
            return;
        end
        if (len > int'(MAX_PAYLOAD)) begin
            push_ev(EV_ERR, 0, 0, 0);
            return;
        end
        for (int i = 0; i < pay && i < len; i++) push_ev(EV_READ, b[0], b[3 + i], 16'(i));
        if (pay >= len) begin
            push_ev(EV_DONE, 0, 0, 0);
            if (pay > len) push_ev(EV_ERR, 0, 0, 0);
        end else if (cs_falls) begin
            push_ev(EV_ERR, 0, 0, 0);
        end
    endtask

    // Whether the framer should still be waiting for header or payload bytes.
    function automatic logic model_busy(input byte_q_t b);
        int len;
        if (b.size() == 0) return 1'b0;
        if (b.size() < 3) return 1'b1;
        len = int'(b[1]) * 256 + int'(b[2]);
        return (len != 0) && (len <= int'(MAX_PAYLOAD)) && (b.size() - 3 < len);
    endfunction

    task automatic expect_event(input ev_kind_t k);
        ev_t e;
        check($sformatf("strobe_expected_%s", k.name()), exp_q.size() != 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("event_kind", e.kind, k);
        if (k == EV_READ && e.kind == EV_READ) begin
            check("read_data", data, e.data);
            check("read_index", data_index, e.idx);
            check("read_command", command, e.cmd);
        end
    endtask

    // Monitor: compares every strobe against the head of the scoreboard.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (frame_done || frame_error)
                check("done_error_exclusive", frame_done & frame_error, 0);
            if (data_read)   expect_event(EV_READ);
            if (frame_done)  expect_event(EV_DONE);
            if (frame_error) expect_event(EV_ERR);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit drop_cs);
        @(posedge clock); #1;
        rx_byte  = b;
        rx_valid = 1'b1;
        if (drop_cs) cs_active = 1'b0;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic cs_up();
        @(posedge clock); #1;
        cs_active = 1'b1;
        idle(2);
    endtask

    // One complete chip-select transaction with scoreboard bookkeeping.
    task automatic run_frame(input byte_q_t b, input bit coincident, input int max_gap);
        model_frame(b, 1'b1);
        cs_up();
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], coincident && (i == b.size() - 1));
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        if (!(coincident && b.size() > 0)) begin
            @(negedge clock);
            check("busy_before_cs_fall", busy, model_busy(b));
            @(posedge clock); #1;
            cs_active = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        check("busy_after_cs_fall", busy, 0);
        idle(2);
    endtask

    initial begin
        byte_q_t b;
        reset = 1'b1; cs_active = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
        idle(3);
        @(negedge clock);
        check("reset_command", command, 0);
        check("reset_data", data, 0);
        check("reset_index", data_index, 0);
        check("reset_strobes", {data_read, frame_done, frame_error}, 0);
        check("reset_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);

        // Three-byte payload, then zero-length frame followed by a one-byte frame.
        run_frame('{8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC}, 1'b0, 0);
        run_frame('{8'h05, 8'h00, 8'h00}, 1'b0, 0);
        run_frame('{8'h07, 8'h00, 8'h01, 8'h11}, 1'b0, 1);
        // Truncated payload, overrun after completion, oversize header.
        run_frame('{8'h01, 8'h00, 8'h04, 8'h21, 8'h22}, 1'b0, 0);
        run_frame('{8'h03, 8'h00, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88}, 1'b0, 0);
        run_frame('{8'h01, 8'h00, 8'h11, 8'h12, 8'h13}, 1'b0, 0);
        // Exactly MAX_PAYLOAD bytes, and chip-select falling with the last byte.
        b = '{8'h04, 8'h00, 8'h10};
        for (int i = 0; i < 16; i++) b.push_back(8'(8'hC0 + i));
        run_frame(b, 1'b0, 0);
        run_frame('{8'h04, 8'h00, 8'h02, 8'hA1, 8'hA2}, 1'b1, 0);
        run_frame('{8'h04, 8'h00, 8'h03, 8'hA1, 8'hA2}, 1'b1, 0);
        run_frame('{8'h06, 8'h00}, 1'b0, 0);
        run_frame('{}, 1'b0, 0);

        // Reset mid-payload with chip-select held high: later bytes are ignored.
        b = '{8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB};
        model_frame(b, 1'b0);
        cs_up();
        foreach (b[i]) send_byte(b[i], 1'b0);
        idle(1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_command", command, 0);
        check("post_reset_index", data_index, 0);
        check("post_reset_busy", busy, 0);
        b = '{8'h09, 8'h00, 8'h01, 8'h42};
        foreach (b[i]) send_byte(b[i], 1'b0);
        idle(3);
        cs_active = 1'b0;
        idle(2);
        run_frame('{8'h09, 8'h00, 8'h01, 8'h42}, 1'b0, 0);

        // Randomised frames: lengths around and beyond MAX_PAYLOAD,
        // truncation, overrun and coincident chip-select falls.
        for (int f = 0; f < 60; f++) begin
            int len, pay, n;
            b = {};
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(0, 2);
                for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            end else begin
                len = $urandom_range(0, 20);
                pay = (len > 16) ? $urandom_range(0, 2) : len + $urandom_range(0, 4) - 2;
                if (pay < 0) pay = 0;
                b.push_back(8'($urandom));
                b.push_back(8'h00);
                b.push_back(8'(len));
                for (int i = 0; i < pay; i++) b.push_back(8'($urandom));
            end
            run_frame(b, $urandom_range(0, 3) == 0, 2);
        end

        idle(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
